// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared state, entry types and reset address for the instruction-fetch front end
package instr_fetch_pkg;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-bus request/response handshake between fetch (master) and memory (slave)
interface instr_fetch_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    modport master(output ireq_valid, ireq_addr, input iresp_addr_ok, iresp_data_ok, iresp_data);
    modport slave(input ireq_valid, ireq_addr, output iresp_addr_ok, iresp_data_ok, iresp_data);
endinterface

// File: rtl/instr_fetch_fifo.sv
// instr_fifo: circular buffer of fetched {pc, instr} entries with push/pop/flush; head reads zero when empty
module instr_fifo import instr_fetch_pkg::*; #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_pop;
    assign do_pop = pop && count != '0;
    assign head = count == '0 ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, single-outstanding instruction-bus master and decode-side instruction FIFO.
// Define IFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module instr_fetch import instr_fetch_pkg::*; #(
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus,
    output logic [31:0]   instr_o,
    output logic [31:0]   pc_o,
    output logic          i_valid_o,
    input  logic          stall_i,
    input  logic          redirect_valid_i,
    input  logic [31:0]   redirect_pc_i
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    fetch_state_t  state, next;
    logic [31:0]   pc, req_addr;
    logic          held, drop_pend, accept, push_ok, push, pop, bypass;
    logic [CW-1:0] count;
    fetch_entry_t  head, din;
    // a request once raised stays up (with its address) until accepted, even across a redirect
    assign bus.ireq_valid = !reset && state == S_REQ && (held || count < CW'(BUF_DEPTH));
    assign bus.ireq_addr  = held ? req_addr : {pc[31:2], 2'b00};
    assign accept  = bus.ireq_valid && bus.iresp_addr_ok;
    assign push_ok = !redirect_valid_i && bus.iresp_data_ok && (state == S_WAIT || (accept && !drop_pend));
    assign din     = '{pc: state == S_WAIT ? req_addr : bus.ireq_addr, instr: bus.iresp_data};
`ifdef IFETCH_BYPASS_EN
    assign bypass = push_ok && count == '0;
    assign push   = push_ok && !(bypass && !stall_i);
`else
    assign bypass = 1'b0;
    assign push   = push_ok;
`endif
    assign pop       = count != '0 && !stall_i;
    assign i_valid_o = bypass || count != '0;
    assign {pc_o, instr_o} = bypass ? din : head;
    assign next = accept ? (bus.iresp_data_ok ? S_REQ : (redirect_valid_i || drop_pend) ? S_DROP : S_WAIT)
                : state == S_REQ ? S_REQ
                : bus.iresp_data_ok ? S_REQ
                : (state == S_WAIT && redirect_valid_i) ? S_DROP : state;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_addr  <= '0;
            held      <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            state     <= next;
            if (bus.ireq_valid) req_addr <= bus.ireq_addr;
            held      <= bus.ireq_valid && !bus.iresp_addr_ok;
            drop_pend <= bus.ireq_valid && !bus.iresp_addr_ok && (drop_pend || redirect_valid_i);
            pc        <= redirect_valid_i ? redirect_pc_i : (accept && !drop_pend) ? pc + 32'd4 : pc;
        end
    end
    instr_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(redirect_valid_i),
        .din(din),
        .head(head),
        .count(count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: bus-slave model with random timing; the consumed stream must be word(pc) for
// consecutive PCs starting at the reset address or the latest redirect target.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef IFETCH_BYPASS_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redir = 1'b0;
    logic [31:0] redir_pc = '0, instr, pc;
    logic        i_valid;
    int          errors = 0, checks = 0;
    logic        busy = 1'b0, prev_held = 1'b0, redir_prev = 1'b0;
    logic [31:0] slv_addr = '0, prev_addr = '0, exp_pc = RST_PC;
    int          slv_cnt = 0, slv_wait = 0, cur_lat = 0, addr_k = 0, lat_k = 0;
    int          consumed = 0, accepts = 0;
    instr_fetch_if bus();
    instr_fetch #(.BUF_DEPTH(2), .RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .instr_o(instr),
        .pc_o(pc),
        .i_valid_o(i_valid),
        .stall_i(stall),
        .redirect_valid_i(redir),
        .redirect_pc_i(redir_pc)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction
    function automatic int draw(input int k, input int hi);
        return k < 0 ? int'($urandom_range(0, hi)) : k;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic drive();
        #1;
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = $urandom;
        if (busy) begin
            if (slv_cnt == 0) begin
                bus.iresp_data_ok = 1'b1;
                bus.iresp_data    = word(slv_addr);
            end
        end else if (bus.ireq_valid && slv_wait == 0) begin
            bus.iresp_addr_ok = 1'b1;
            cur_lat = draw(lat_k, 3);
            if (cur_lat == 0) begin
                bus.iresp_data_ok = 1'b1;
                bus.iresp_data    = word(bus.ireq_addr);
            end
        end
        #1;
    endtask
    task automatic advance();
        logic v, aok, dok, rst, rdr, cons;
        logic [31:0] a, rp;
        #1;
        v = bus.ireq_valid; a = bus.ireq_addr; aok = bus.iresp_addr_ok; dok = bus.iresp_data_ok;
        rst = reset; rdr = redir; rp = redir_pc;
        cons = i_valid && !stall && !redir && !reset;
        if (!rst) begin
            if (busy) chk("one_outstanding", v, 0);
            if (prev_held) begin
                chk("held_valid", v, 1);
                chk("held_addr", a, prev_addr);
            end
`ifndef IFETCH_BYPASS_EN
            if (redir_prev) chk("flush_ivalid", i_valid, 0);
`endif
            if (cons) begin
                chk("pc_seq", pc, exp_pc);
                chk("instr", instr, word(exp_pc));
                consumed++;
            end
        end
        @(posedge clk);
        if (rst) begin
            busy = 1'b0; prev_held = 1'b0; redir_prev = 1'b0; exp_pc = RST_PC;
            slv_wait = draw(addr_k, 2);
        end else begin
            prev_held  = v && !aok;
            prev_addr  = a;
            redir_prev = rdr;
            exp_pc = rdr ? rp : cons ? exp_pc + 32'd4 : exp_pc;
            if (busy) begin
                if (dok) busy = 1'b0;
                else slv_cnt--;
            end else if (v) begin
                if (aok) begin
                    accepts++;
                    slv_wait = draw(addr_k, 2);
                    if (cur_lat > 0) begin
                        busy = 1'b1; slv_addr = a; slv_cnt = cur_lat - 1;
                    end
                end else slv_wait--;
            end
        end
        #1;
    endtask
    task automatic cycle();
        drive();
        advance();
    endtask
    initial begin
        int n, a0, c0;
        logic [31:0] ha, t;
        bus.iresp_addr_ok = 1'b0; bus.iresp_data_ok = 1'b0; bus.iresp_data = '0;
        cycle();
        cycle();
        chk("rst_ireq_valid", bus.ireq_valid, 0);
        chk("rst_ivalid", i_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive();
            chk("seq_req_valid", bus.ireq_valid, 1);
            chk("seq_req_addr", bus.ireq_addr, RST_PC + 32'(4 * k));
            if (k > 0) begin
                chk("seq_ivalid", i_valid, 1);
                chk("seq_pc", pc, RST_PC + 32'(4 * (k - OFF)));
            end
            advance();
        end
        redir = 1'b1; redir_pc = 32'h0000_2000;
        cycle();
        redir = 1'b0; stall = 1'b1; a0 = accepts;
        repeat (5) cycle();
        chk("stall_reqs", 32'(accepts - a0), 2);
        drive();
        chk("stall_idle", bus.ireq_valid, 0);
        stall = 1'b0;
        chk("stall_head_valid", i_valid, 1);
        chk("stall_head_pc", pc, 32'h0000_2000);
        advance();
        lat_k = 3; n = 0;
        while (!busy && n < 20) begin cycle(); n++; end
        chk("wait_reached", busy, 1);
        redir = 1'b1; redir_pc = 32'h8000_1000;
        cycle();
        redir = 1'b0; n = 0;
        drive();
        while (!bus.ireq_valid && n < 20) begin advance(); drive(); n++; end
        chk("drop_next_addr", bus.ireq_addr, 32'h8000_1000);
        advance();
        n = 0;
        drive();
        while (!i_valid && n < 20) begin advance(); drive(); n++; end
        chk("drop_first_pc", pc, 32'h8000_1000);
        advance();
        addr_k = 3; lat_k = 1; n = 0;
        drive();
        while (!(bus.ireq_valid && slv_wait == 3) && n < 40) begin advance(); drive(); n++; end
        chk("hold_setup", bus.ireq_valid && slv_wait == 3, 1);
        ha = bus.ireq_addr; redir = 1'b1; redir_pc = 32'h8000_2000;
        advance();
        redir = 1'b0; n = 0;
        drive();
        while (!bus.iresp_addr_ok && n < 10) begin
            chk("held_addr_kept", bus.ireq_addr, ha);
            advance(); drive(); n++;
        end
        chk("held_accept_addr", bus.ireq_addr, ha);
        advance();
        n = 0;
        drive();
        while (!bus.ireq_valid && n < 10) begin advance(); drive(); n++; end
        chk("after_drop_addr", bus.ireq_addr, 32'h8000_2000);
        advance();
        addr_k = 0; lat_k = 3; stall = 1'b1; n = 0;
        while (!(busy && i_valid) && n < 40) begin cycle(); n++; end
        chk("reach_wait_buf", busy && i_valid, 1);
        reset = 1'b1;
        cycle();
        chk("mid_rst_ivalid", i_valid, 0);
        chk("mid_rst_ireq", bus.ireq_valid, 0);
        cycle();
        reset = 1'b0; stall = 1'b0; lat_k = 0;
        drive();
        chk("restart_valid", bus.ireq_valid, 1);
        chk("restart_addr", bus.ireq_addr, RST_PC);
        advance();
        drive();
        stall = 1'b1; redir = 1'b1; redir_pc = 32'h0000_3000;
        advance();
        stall = 1'b0; redir = 1'b0;
`ifndef IFETCH_BYPASS_EN
        chk("combo_flush_ivalid", i_valid, 0);
`endif
        drive();
        chk("combo_next_addr", bus.ireq_addr, 32'h0000_3000);
        advance();
        addr_k = -1; lat_k = -1; c0 = consumed;
        repeat (1500) begin
            stall = $urandom_range(0, 9) < 3;
            redir = $urandom_range(0, 31) == 0;
            t = $urandom;
            redir_pc = {t[31:2], 2'b00};
            cycle();
        end
        stall = 1'b0; redir = 1'b0;
        repeat (20) cycle();
        chk("progress", 32'(consumed - c0 > 150), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
